// File: rtl/sa_cache.sv
// sa_cache: N-way set-associative, write-through, no-write-allocate data cache.
// Read hits complete in zero cycles; read misses refill a whole line from word-wide memory.
module sa_cache #(
    parameter int WIDTH          = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int SETS           = 16,
    parameter int WAYS           = 2,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      write_data,
    input  logic [2:0]            AddrMode,
    output logic [WIDTH-1:0]      read_data,
    output logic                  stall,
    output logic                  hit,
    output logic                  miss,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ack
);
    localparam int WB  = $clog2(WORDS_PER_LINE);
    localparam int WBW = (WB > 0) ? WB : 1;
    localparam int IB  = $clog2(SETS);
    localparam int TB  = ADDR_WIDTH - 2 - WB - IB;
    localparam int VB  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << (2 + WB);

    typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;
    state_t r_state, w_next;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_mode;
    logic [WIDTH-1:0]      r_wdata;
    logic                  r_isLoad;
    logic [VB-1:0]         r_way;
    logic                  r_replace;
    logic [WBW-1:0]        r_cnt;

    logic [WAYS-1:0]  r_valid [SETS];
    logic [VB-1:0]    r_ptr   [SETS];
    logic [TB-1:0]    r_tag   [WAYS][SETS];
    logic [WIDTH-1:0] r_data  [WAYS][SETS][WORDS_PER_LINE];

    logic [ADDR_WIDTH-1:0] w_addr;
    logic [2:0]            w_mode;
    logic [IB-1:0]         w_idx;
    logic [TB-1:0]         w_tag;
    logic [WBW-1:0]        w_word;
    logic                  w_hit;
    logic [VB-1:0]         w_hitWay;
    logic [VB-1:0]         w_victim;
    logic                  w_replace;
    logic                  w_last;
    logic [WIDTH-1:0]      w_hitWord;
    logic [3:0]            w_be;
    logic [WIDTH-1:0]      w_wdLane;

    function automatic logic [3:0] laneEnable(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   laneEnable = 4'b0001 << off;
            2'b01:   laneEnable = 4'b0011 << {off[1], 1'b0};
            default: laneEnable = 4'b1111;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] laneData(input logic [1:0] size, input logic [1:0] off,
                                                  input logic [WIDTH-1:0] wd);
        case (size)
            2'b00:   laneData = {24'b0, wd[7:0]} << {off, 3'b000};
            2'b01:   laneData = {16'b0, wd[15:0]} << {off[1], 4'b0000};
            default: laneData = wd;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] loadExtract(input logic [WIDTH-1:0] word,
                                                     input logic [2:0] mode, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (mode)
            3'b000:  loadExtract = {{24{b[7]}}, b};
            3'b100:  loadExtract = {24'b0, b};
            3'b001:  loadExtract = {{16{h[15]}}, h};
            3'b101:  loadExtract = {16'b0, h};
            default: loadExtract = word;
        endcase
    endfunction

    // Outside IDLE the lookup runs on the latched request so DONE sees the resident line.
    assign w_addr = (r_state == IDLE) ? addr : r_addr;
    assign w_mode = (r_state == IDLE) ? AddrMode : r_mode;
    assign w_idx  = w_addr[2+WB +: IB];
    assign w_tag  = w_addr[ADDR_WIDTH-1 -: TB];

    generate
        if (WB > 0) begin : g_word
            assign w_word = w_addr[2 +: WBW];
        end else begin : g_noWord
            assign w_word = '0;
        end
    endgenerate

    assign w_last    = (r_cnt == WBW'(WORDS_PER_LINE - 1));
    assign w_hitWord = r_data[w_hitWay][w_idx][w_word];
    assign w_be      = laneEnable(r_mode[1:0], r_addr[1:0]);
    assign w_wdLane  = laneData(r_mode[1:0], r_addr[1:0], r_wdata);

    always_comb begin
        w_hit    = 1'b0;
        w_hitWay = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit    = 1'b1;
                w_hitWay = VB'(w);
            end
        end
    end

    // Lowest-numbered invalid way wins; otherwise the round-robin pointer picks the victim.
    always_comb begin
        w_victim  = r_ptr[w_idx];
        w_replace = 1'b1;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_victim  = VB'(w);
                w_replace = 1'b0;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        stall     = 1'b0;
        hit       = 1'b0;
        miss      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        read_data = '0;
        case (r_state)
            IDLE: begin
                if (write_en) begin
                    stall  = 1'b1;
                    hit    = w_hit;
                    w_next = WRITE;
                end else if (read_en) begin
                    if (w_hit) begin
                        hit       = 1'b1;
                        read_data = loadExtract(w_hitWord, w_mode, w_addr[1:0]);
                    end else begin
                        miss   = 1'b1;
                        stall  = 1'b1;
                        w_next = REFILL;
                    end
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = (r_addr & LINE_MASK) | (ADDR_WIDTH'(r_cnt) << 2);
                if (mem_ack && w_last) w_next = DONE;
            end
            WRITE: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
                mem_wdata = w_wdLane;
                mem_be    = w_be;
                if (mem_ack) w_next = DONE;
            end
            DONE: begin
                if (r_isLoad) read_data = loadExtract(w_hitWord, w_mode, w_addr[1:0]);
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (rst) begin
            stall     = 1'b0;
            hit       = 1'b0;
            miss      = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            mem_be    = 4'b0000;
            read_data = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_mode    <= 3'b000;
            r_wdata   <= '0;
            r_isLoad  <= 1'b0;
            r_way     <= '0;
            r_replace <= 1'b0;
            r_cnt     <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
            end
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                if (write_en) begin
                    r_addr   <= addr;
                    r_mode   <= AddrMode;
                    r_wdata  <= write_data;
                    r_isLoad <= 1'b0;
                end else if (read_en && !w_hit) begin
                    r_addr    <= addr;
                    r_mode    <= AddrMode;
                    r_isLoad  <= 1'b1;
                    r_way     <= w_victim;
                    r_replace <= w_replace;
                    r_cnt     <= '0;
                    r_valid[w_idx][w_victim] <= 1'b0;
                end
            end else if (r_state == REFILL && mem_ack) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_valid[w_idx][r_way] <= 1'b1;
                    if (r_replace && WAYS > 1) r_ptr[w_idx] <= r_ptr[w_idx] + 1'b1;
                end
            end
        end
    end

    // Line storage carries no reset; the valid bits alone decide what is resident.
    always_ff @(posedge clk) begin
        if (r_state == REFILL && mem_ack) begin
            r_data[r_way][w_idx][r_cnt] <= mem_rdata;
            if (w_last) r_tag[r_way][w_idx] <= w_tag;
        end
        if (r_state == WRITE && mem_ack && w_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_data[w_hitWay][w_idx][w_word][8*b +: 8] <= w_wdLane[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_sa_cache.sv
// tb_sa_cache: directed test of sa_cache (16 sets, 2 ways, 4 words/line) against a word memory model.
module tb_sa_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic        read_en, write_en;
    logic [31:0] addr, write_data;
    logic [2:0]  AddrMode;
    logic [31:0] read_data;
    logic        stall, hit, miss;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int          checks = 0;
    int          fails  = 0;
    int          readCount  = 0;
    int          writeCount = 0;
    int          waitCnt    = 0;
    int          ackDelay   = 1;
    bit          ackTied    = 1'b0;
    logic [31:0] memory [0:4095];

    sa_cache #(.WIDTH(32), .ADDR_WIDTH(32), .SETS(16), .WAYS(2), .WORDS_PER_LINE(4)) dut (
        .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en), .addr(addr),
        .write_data(write_data), .AddrMode(AddrMode), .read_data(read_data), .stall(stall),
        .hit(hit), .miss(miss), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Memory responder: decides ack on the falling edge, commits the transfer just before the rising edge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (ackTied) mem_ack = 1'b1;
            else if (mem_ack) begin
                mem_ack = 1'b0;
                waitCnt = 0;
            end else if (mem_req) begin
                if (waitCnt >= ackDelay) mem_ack = 1'b1;
                else waitCnt++;
            end else waitCnt = 0;
            mem_rdata = memory[mem_addr[13:2]];
            #4;
            if (mem_req && mem_ack) begin
                if (mem_we) begin
                    writeCount++;
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) memory[mem_addr[13:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end else readCount++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic re, input logic we, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [2:0] m);
        read_en    = re;
        write_en   = we;
        addr       = a;
        write_data = wd;
        AddrMode   = m;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic resetPulse;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic doLoad(input string tag, input logic [31:0] a, input logic [2:0] m,
                          input logic expHit, input logic [31:0] expData, output int stallCycles);
        int base;
        base        = readCount;
        stallCycles = 0;
        applyStimulus(1'b1, 1'b0, a, 32'h0, m);
        #1;
        checkOutput({tag, ".hit"}, hit, expHit);
        checkOutput({tag, ".miss"}, miss, !expHit);
        checkOutput({tag, ".stall"}, stall, !expHit);
        if (expHit) begin
            checkOutput({tag, ".data"}, read_data, expData);
            tick;
        end else begin
            stallCycles = 1;
            tick;
            checkOutput({tag, ".memAddr"}, mem_addr, a & ~32'hF);
            checkOutput({tag, ".memWe"}, mem_we, 1'b0);
            for (int i = 0; i < 60 && stall; i++) begin
                stallCycles++;
                tick;
            end
            checkOutput({tag, ".doneStall"}, stall, 1'b0);
            checkOutput({tag, ".doneData"}, read_data, expData);
            checkOutput({tag, ".reads"}, readCount - base, 4);
            tick;
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    endtask

    task automatic doStore(input string tag, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] m, input logic expHit, input logic both,
                           input logic [31:0] expAddr, input logic [3:0] expBe,
                           input logic [31:0] expWdata, output int reqCycles);
        int base;
        base      = writeCount;
        reqCycles = 0;
        applyStimulus(both, 1'b1, a, wd, m);
        #1;
        checkOutput({tag, ".hit"}, hit, expHit);
        checkOutput({tag, ".miss"}, miss, 1'b0);
        checkOutput({tag, ".stall"}, stall, 1'b1);
        tick;
        checkOutput({tag, ".memReq"}, mem_req, 1'b1);
        checkOutput({tag, ".memWe"}, mem_we, 1'b1);
        checkOutput({tag, ".memAddr"}, mem_addr, expAddr);
        checkOutput({tag, ".memBe"}, mem_be, expBe);
        checkOutput({tag, ".memWdata"}, mem_wdata, expWdata);
        for (int i = 0; i < 60 && stall; i++) begin
            reqCycles++;
            tick;
        end
        checkOutput({tag, ".doneStall"}, stall, 1'b0);
        checkOutput({tag, ".writes"}, writeCount - base, 1);
        tick;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    endtask

    initial begin
        int sc;
        int base;
        for (int i = 0; i < 4096; i++) memory[i] = {16'hC0DE, 16'(i)};
        memory[12'h040] = 32'h11;
        memory[12'h041] = 32'h22;
        memory[12'h042] = 32'h33;
        memory[12'h043] = 32'h44;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        tick;
        tick;
        checkOutput("rst.stall", stall, 1'b0);
        checkOutput("rst.hit", hit, 1'b0);
        checkOutput("rst.miss", miss, 1'b0);
        checkOutput("rst.memReq", mem_req, 1'b0);
        checkOutput("rst.memWe", mem_we, 1'b0);
        checkOutput("rst.memAddr", mem_addr, 32'h0);
        checkOutput("rst.memBe", mem_be, 4'h0);
        checkOutput("rst.memWdata", mem_wdata, 32'h0);
        checkOutput("rst.readData", read_data, 32'h0);
        rst = 1'b0;
        tick;
        checkOutput("idle.readData", read_data, 32'h0);
        checkOutput("idle.stall", stall, 1'b0);

        $display("[TB] cold load and hits");
        doLoad("coldLW100", 32'h100, 3'b010, 1'b0, 32'h11, sc);
        doLoad("hitLW108", 32'h108, 3'b010, 1'b1, 32'h33, sc);

        $display("[TB] store hit merge and sub-word loads");
        doStore("sb101", 32'h101, 32'h0000_00AB, 3'b000, 1'b1, 1'b0, 32'h100, 4'b0010, 32'h0000_AB00, sc);
        doLoad("lbu101", 32'h101, 3'b100, 1'b1, 32'h0000_00AB, sc);
        doLoad("lb101", 32'h101, 3'b000, 1'b1, 32'hFFFF_FFAB, sc);
        doLoad("lhu100", 32'h100, 3'b101, 1'b1, 32'h0000_AB11, sc);
        doLoad("lh100", 32'h100, 3'b001, 1'b1, 32'hFFFF_AB11, sc);
        doLoad("lh102", 32'h102, 3'b001, 1'b1, 32'h0000_0000, sc);
        doLoad("lw100", 32'h100, 3'b010, 1'b1, 32'h0000_AB11, sc);
        doStore("swBoth108", 32'h108, 32'h55, 3'b010, 1'b1, 1'b1, 32'h108, 4'b1111, 32'h55, sc);
        doLoad("lw10B", 32'h10B, 3'b010, 1'b1, 32'h55, sc);

        $display("[TB] store miss without allocation");
        doStore("sw2000", 32'h2000, 32'hDEAD_BEEF, 3'b010, 1'b0, 1'b0, 32'h2000, 4'b1111, 32'hDEAD_BEEF, sc);
        doLoad("lw2000", 32'h2000, 3'b010, 1'b0, 32'hDEAD_BEEF, sc);
        doLoad("lw10C", 32'h10C, 3'b010, 1'b1, 32'h44, sc);

        $display("[TB] round-robin replacement in set 0");
        resetPulse;
        doLoad("rep000", 32'h000, 3'b010, 1'b0, 32'hC0DE_0000, sc);
        doLoad("rep100", 32'h100, 3'b010, 1'b0, 32'h0000_AB11, sc);
        doLoad("rep200", 32'h200, 3'b010, 1'b0, 32'hC0DE_0080, sc);
        doLoad("rep100hit", 32'h100, 3'b010, 1'b1, 32'h0000_AB11, sc);
        doLoad("rep000miss", 32'h000, 3'b010, 1'b0, 32'hC0DE_0000, sc);
        doLoad("rep200hit", 32'h200, 3'b010, 1'b1, 32'hC0DE_0080, sc);
        doLoad("rep100miss", 32'h100, 3'b010, 1'b0, 32'h0000_AB11, sc);

        $display("[TB] reset in the middle of a refill");
        base = readCount;
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 3'b010);
        #1;
        checkOutput("midRst.miss", miss, 1'b1);
        for (int i = 0; i < 40 && (readCount - base) < 2; i++) tick;
        checkOutput("midRst.reqBefore", mem_req, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midRst.reqAfter", mem_req, 1'b0);
        checkOutput("midRst.stall", stall, 1'b0);
        checkOutput("midRst.reads", readCount - base, 2);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        tick;
        rst = 1'b0;
        tick;
        doLoad("refetch300", 32'h300, 3'b010, 1'b0, 32'hC0DE_00C0, sc);
        doLoad("afterRst000", 32'h000, 3'b010, 1'b0, 32'hC0DE_0000, sc);

        $display("[TB] memory acknowledging in the request cycle");
        resetPulse;
        ackTied = 1'b1;
        tick;
        doLoad("tiedLW100", 32'h100, 3'b010, 1'b0, 32'h0000_AB11, sc);
        checkOutput("tiedLW100.stallCycles", sc, 5);
        doStore("tiedSH106", 32'h106, 32'h0000_1234, 3'b001, 1'b1, 1'b0, 32'h104, 4'b1100, 32'h1234_0000, sc);
        checkOutput("tiedSH106.writeCycles", sc, 1);
        doLoad("tiedLW104", 32'h104, 3'b010, 1'b1, 32'h1234_0022, sc);
        doLoad("tiedLHU106", 32'h106, 3'b101, 1'b1, 32'h0000_1234, sc);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/sa_cache.md
Name: sa_cache

Overview:
- Parametrised N-way set-associative data cache; successor to the direct-mapped cache stub.
- Sits between the MEM stage (ALUResult_M / WriteData_M / AddrMode_M) and a word-wide backing memory.
- Write-through, no-write-allocate, line refill on read miss.
- Asserts stall to freeze the pipeline while memory traffic is outstanding.

Parameters:
- WIDTH, 32, data word width (fixed 32 for byte-lane logic).
- ADDR_WIDTH, 32, byte address width.
- SETS, 16, number of sets; power of 2, ≥2.
- WAYS, 2, associativity; power of 2, 1..8.
- WORDS_PER_LINE, 4, words per line; power of 2, ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- read_en  in  1  load request this cycle.
- write_en  in  1  store request this cycle.
- addr  in  ADDR_WIDTH  byte address.
- write_data  in  WIDTH  store data, right-aligned.
- AddrMode  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- read_data  out  WIDTH  load result, sign/zero extended.
- stall  out  1  hold pipeline; request not yet complete.
- hit  out  1  one-cycle pulse: lookup hit.
- miss  out  1  one-cycle pulse: read lookup missed.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a write.
- mem_addr  out  ADDR_WIDTH  word-aligned memory address.
- mem_wdata  out  WIDTH  memory write word, byte-lane positioned.
- mem_be  out  4  write byte enables.
- mem_rdata  in  WIDTH  memory read word, valid with mem_ack.
- mem_ack  in  1  completes current request; may arrive the same cycle as mem_req.

Behaviour:
- Address split: offset[1:0], word = next log2(WORDS_PER_LINE) bits, index = next log2(SETS) bits, tag = the remaining bits.
- Storage per way/set: valid bit, tag, line data. Per set: round-robin victim pointer of log2(WAYS) bits.
- Reset (async): all valid bits 0, victim pointers 0, FSM to IDLE. Outputs stall, hit, miss, mem_req, mem_we are 0. mem_be, mem_addr, mem_wdata and read_data are 0.
- FSM states: IDLE, REFILL, WRITE, DONE.
- IDLE, read hit: hit=1. read_data is valid combinationally the same cycle. stall=0. Zero-latency hit.
- IDLE, read miss: miss=1 and stall=1 combinationally. Latch addr and AddrMode, then go to REFILL.
- Victim selection: lowest-numbered invalid way in the set; if all ways are valid, the way at the victim pointer.
- REFILL:
  - Issue WORDS_PER_LINE reads starting at word 0 of the line, with mem_we=0.
  - mem_req stays high and mem_addr stays stable until mem_ack.
  - Each ack writes mem_rdata into the victim line at the current word counter.
  - On the last ack: set valid and tag, advance the victim pointer mod WAYS only if the victim was a replacement (not an invalid fill), then go to DONE. stall=1 throughout.
- IDLE, write (write_en=1):
  - stall=1; hit pulses if the tag matches. Latch the request and go to WRITE.
  - Byte lanes: B stores write_data[7:0] on lane addr[1:0]. H stores write_data[15:0] on lanes {addr[1],0},{addr[1],1}. W stores all lanes.
  - mem_be: 0001<<addr[1:0] for B; 0011<<{addr[1],0} for H; 1111 for W.
- WRITE:
  - mem_req=1, mem_we=1 with aligned address, lane-positioned data and mem_be, held until mem_ack.
  - On ack, if the line hit, merge the enabled bytes into the cached word. Then go to DONE.
  - A miss never allocates; miss is not pulsed for writes.
- DONE:
  - stall=0 for one cycle. For loads, read_data comes from the now-resident line.
  - Return to IDLE next cycle. The pipeline advances this cycle, so the same request is not re-evaluated.
- Load extraction: B/BU select byte addr[1:0]; H/HU select half addr[1]; W returns the whole word. B/H sign-extend, BU/HU zero-extend.
- Misalignment: low address bits beyond the access size are ignored; no trap.
- Simultaneous read_en and write_en: handled as a write.
- Neither enable asserted: read_data=0, no pulses, stall=0.
- Reset mid-REFILL or mid-WRITE: mem_req drops immediately; the partial line is never validated.
- Requests arriving while not in IDLE are ignored; the core holds them under stall.

Test Plan:
- Cold load: reset, read_en addr 0x100 W, memory returns 0x11,0x22,0x33,0x44 at 0x100..0x10C with 1-cycle ack delay. Expect miss pulse, 4 mem reads, stall high then DONE with read_data=0x11. Then LW 0x108 → hit=1, read_data=0x33, stall=0 same cycle.
- Store hit merge: after line 0x100 is resident, SB 0xAB to 0x101. Expect mem_be=0010, mem_wdata=0x0000AB00, mem_addr=0x100. Then LBU 0x101 → 0xAB and LB 0x101 → 0xFFFFFFAB, both hits.
- Store miss no-allocate: SW 0xDEADBEEF to 0x2000 → one memory write, mem_be=1111. Then LW 0x2000 → miss and refill.
- Replacement (SETS=16, WAYS=2, 4 words/line): fill tags via 0x000, 0x100, 0x200, all set 0. The third load evicts way0 (0x000). Then LW 0x100 hits; LW 0x000 misses and evicts way1 (0x100).
- Async reset during REFILL after 2 acks: mem_req falls without a clock edge. A subsequent LW to the same line misses and refetches all 4 words.
- Same-cycle ack (mem_ack tied high): read miss completes in WORDS_PER_LINE+1 stall cycles. A write completes in 1 stall cycle followed by DONE.
